image_write_stream: RTL and testbench

- Sink-side counterpart to the image read/brightness path.
- Captures one processed frame of RGB pixels, presented one pixel per handshake in raster order, into an internal frame buffer.
- Then serialises the frame as a byte stream (R,G,B per pixel) for the hex/BMP output writer or a host link.
- Sits at the tail of the pipeline, after brightness/contrast/threshold stages.

---
 rtl/image_pkg.sv | 21 ++
 rtl/image_frame_buffer.sv | 27 ++
 rtl/image_write_stream.sv | 185 ++++++++++++++++++
 tb/tb_image_write_stream.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared definitions for the image write path: FSM state encoding,
// component select codes and a width helper for counters and addresses.
package image_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DUMP    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] COMP_R = 2'd0;
  localparam logic [1:0] COMP_G = 2'd1;
  localparam logic [1:0] COMP_B = 2'd2;

  // Bits needed to index n items, never less than one bit.
  function automatic int widthOf(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_frame_buffer.sv
// Frame storage: one 24-bit {R,G,B} word per pixel, written on the clock
// edge and read combinationally so the byte serialiser sees data at once.
module image_frame_buffer #(
  parameter int DEPTH = 768 * 512,
  parameter int AW    = 19
) (
  input  logic          clk,
  input  logic          i_wrEn,
  input  logic [AW-1:0] i_wrAddr,
  input  logic [23:0]   i_wrData,
  input  logic [AW-1:0] i_rdAddr,
  output logic [23:0]   o_rdData
);

  logic [23:0] r_mem [DEPTH];

  // Contents are deliberately left unreset; a frame is always fully written
  // before any of it is read back.
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/image_write_stream.sv
// Tail of the image pipeline: captures one frame of RGB pixels in raster
// order, then replays it as an R,G,B byte stream, optionally bottom-up.
module image_write_stream
  import image_pkg::*;
#(
  parameter int HEIGHT    = 768,
  parameter int WIDTH     = 512,
  parameter int BOTTOM_UP = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] R,
  input  logic [7:0] G,
  input  logic [7:0] B,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       frame_done
);

  localparam int NPIX   = HEIGHT * WIDTH;
  localparam int NBYTES = 3 * NPIX;
  localparam int CW     = widthOf(WIDTH);
  localparam int RW     = widthOf(HEIGHT);
  localparam int AW     = widthOf(NPIX);
  localparam int KW     = widthOf(NBYTES);

  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [KW-1:0] BYTE_LAST = KW'(NBYTES - 1);
  localparam logic [AW-1:0] WIDTH_A   = AW'(WIDTH);

  state_t        r_state;
  state_t        w_nextState;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [1:0]    r_comp;
  logic [KW-1:0] r_byteCnt;

  logic          w_accept;
  logic          w_transfer;
  logic          w_lastCol;
  logic          w_lastRow;
  logic          w_lastByte;
  logic [RW-1:0] w_rdRow;
  logic [AW-1:0] w_wrAddr;
  logic [AW-1:0] w_rdAddr;
  logic [23:0]   w_rdData;

  assign in_ready   = (r_state == CAPTURE);
  assign out_valid  = (r_state == DUMP);
  assign busy       = (r_state == CAPTURE) || (r_state == DUMP);
  assign frame_done = (r_state == DONE);

  assign w_accept   = in_valid && in_ready;
  assign w_transfer = out_valid && out_ready;
  assign w_lastCol  = (r_col == COL_LAST);
  assign w_lastRow  = (r_row == ROW_LAST);
  assign w_lastByte = (r_byteCnt == BYTE_LAST);

  // Select the buffer row to replay; bottom-up mirrors the row index only.
  always_comb begin
    w_rdRow = r_row;
    if (BOTTOM_UP != 0) begin
      w_rdRow = ROW_LAST - r_row;
    end
  end

  assign w_wrAddr = AW'(r_row) * WIDTH_A + AW'(r_col);
  assign w_rdAddr = AW'(w_rdRow) * WIDTH_A + AW'(r_col);

  image_frame_buffer #(
    .DEPTH (NPIX),
    .AW    (AW)
  ) u_frameBuffer (
    .clk      (clk),
    .i_wrEn   (w_accept),
    .i_wrAddr (w_wrAddr),
    .i_wrData ({R, G, B}),
    .i_rdAddr (w_rdAddr),
    .o_rdData (w_rdData)
  );

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: start only arms from IDLE or DONE, the final pixel
  // moves to DUMP and the final byte transfer moves to DONE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_nextState = CAPTURE;
        end
      end
      CAPTURE: begin
        if (w_accept && w_lastCol && w_lastRow) begin
          w_nextState = DUMP;
        end
      end
      DUMP: begin
        if (w_transfer && w_lastByte) begin
          w_nextState = DONE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Raster counters are shared: capture walks pixels, dump walks components
  // within each pixel and then the same pixel raster again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_row     <= '0;
      r_comp    <= COMP_R;
      r_byteCnt <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_col     <= '0;
            r_row     <= '0;
            r_comp    <= COMP_R;
            r_byteCnt <= '0;
          end
        end
        CAPTURE: begin
          if (w_accept) begin
            if (w_lastCol) begin
              r_col <= '0;
              r_row <= w_lastRow ? '0 : r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        DUMP: begin
          if (w_transfer) begin
            r_byteCnt <= w_lastByte ? '0 : r_byteCnt + KW'(1);
            if (r_comp == COMP_B) begin
              r_comp <= COMP_R;
              if (w_lastCol) begin
                r_col <= '0;
                r_row <= w_lastRow ? '0 : r_row + RW'(1);
              end else begin
                r_col <= r_col + CW'(1);
              end
            end else begin
              r_comp <= r_comp + 2'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Byte mux over the current pixel word; forced to zero outside DUMP.
  always_comb begin
    out_data = 8'd0;
    if (r_state == DUMP) begin
      case (r_comp)
        COMP_R:  out_data = w_rdData[23:16];
        COMP_G:  out_data = w_rdData[15:8];
        default: out_data = w_rdData[7:0];
      endcase
    end
  end

endmodule

// File: tb/tb_image_write_stream.sv
// Randomised scoreboard bench for image_write_stream: two instances (top-down
// and bottom-up) share one input stream; a monitor pops expected bytes.
module tb_image_write_stream;

  localparam int H      = 2;
  localparam int W      = 3;
  localparam int NPIX   = H * W;
  localparam int NBYTES = 3 * NPIX;

  localparam int M_BASIC    = 0;
  localparam int M_BACKPRES = 1;
  localparam int M_BOUNDARY = 2;
  localparam int M_RESETMID = 3;
  localparam int M_RANDOM   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       inValid;
  logic [7:0] r, g, b;
  logic       outReady;

  logic       inReadyTd, outValidTd, busyTd, frameDoneTd;
  logic [7:0] outDataTd;
  logic       inReadyBu, outValidBu, busyBu, frameDoneBu;
  logic [7:0] outDataBu;

  logic [23:0] frame [NPIX];
  logic [7:0]  expTd [$];
  logic [7:0]  expBu [$];

  int checks = 0;
  int errors = 0;

  logic       prevStall = 1'b0;
  logic [7:0] prevData  = 8'd0;

  always #5 clk = ~clk;

  image_write_stream #(.HEIGHT(H), .WIDTH(W), .BOTTOM_UP(0)) dutTd (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(inValid), .in_ready(inReadyTd),
    .R(r), .G(g), .B(b),
    .out_valid(outValidTd), .out_ready(outReady), .out_data(outDataTd),
    .busy(busyTd), .frame_done(frameDoneTd)
  );

  image_write_stream #(.HEIGHT(H), .WIDTH(W), .BOTTOM_UP(1)) dutBu (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(inValid), .in_ready(inReadyBu),
    .R(r), .G(g), .B(b),
    .out_valid(outValidBu), .out_ready(outReady), .out_data(outDataBu),
    .busy(busyBu), .frame_done(frameDoneBu)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] component(input logic [23:0] pix, input int c);
    if (c == 0) return pix[23:16];
    if (c == 1) return pix[15:8];
    return pix[7:0];
  endfunction

  // Reference model: byte k is component k%3 of pixel k/3 of the emitted
  // raster, where the bottom-up stream reads rows in mirrored order.
  task automatic pushExpected();
    for (int k = 0; k < NBYTES; k++) begin
      int p   = k / 3;
      int row = p / W;
      int col = p % W;
      expTd.push_back(component(frame[row * W + col], k % 3));
      expBu.push_back(component(frame[(H - 1 - row) * W + col], k % 3));
    end
  endtask

  // Monitor: every handshake on either instance pops and compares one byte;
  // a stalled byte on the top-down instance must be held unchanged.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stallValid", outValidTd, 1);
        checkOutput("stallData", outDataTd, prevData);
      end
      prevStall = outValidTd && !outReady;
      prevData  = outDataTd;
      if (outValidTd && outReady) begin
        if (expTd.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL tdUnexpectedByte: got %0d expected none", outDataTd);
        end else begin
          checkOutput("tdByte", outDataTd, expTd.pop_front());
        end
      end
      if (outValidBu && outReady) begin
        if (expBu.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL buUnexpectedByte: got %0d expected none", outDataBu);
        end else begin
          checkOutput("buByte", outDataBu, expBu.pop_front());
        end
      end
    end
  end

  // One complete frame: load data, arm, capture, then drain the byte stream.
  task automatic applyStimulus(input int mode);
    int i, cyc, sent, stallLeft;
    bit acc, stallDone;
    for (int p = 0; p < NPIX; p++) begin
      if (mode == M_BASIC || mode == M_BACKPRES || mode == M_RESETMID)
        frame[p] = {8'(10 * p), 8'(10 * p + 1), 8'(10 * p + 2)};
      else if (mode == M_BOUNDARY)
        frame[p] = (p % 2 == 0) ? 24'h000000 : 24'hFFFFFF;
      else
        frame[p] = 24'($urandom);
    end
    pushExpected();

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("armInReady", inReadyTd, 1);
    checkOutput("armFrameDone", frameDoneTd, 0);
    checkOutput("armBusy", busyTd, 1);

    i = 0; cyc = 0;
    while (i < NPIX && cyc < 200) begin
      if (mode == M_BACKPRES) inValid = cyc[0];
      else if (mode == M_RANDOM) inValid = 1'($urandom_range(0, 1));
      else inValid = 1'b1;
      start = (mode == M_BOUNDARY) ? 1'($urandom_range(0, 1)) : 1'b0;
      {r, g, b} = inValid ? frame[i] : 24'($urandom);
      @(negedge clk);
      acc = inValid && inReadyTd;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    inValid = 1'b0;
    start   = 1'b0;
    checkOutput("captureCount", i, NPIX);
    checkOutput("postCaptureInReady", inReadyTd, 0);
    checkOutput("postCaptureOutValid", outValidTd, 1);
    checkOutput("postCaptureOutValidBu", outValidBu, 1);

    cyc = 0; stallLeft = 0; stallDone = 0;
    while (!frameDoneTd && cyc < 400) begin
      sent = NBYTES - expTd.size();
      if (mode == M_RESETMID && sent == 7) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rstOutValid", outValidTd, 0);
        checkOutput("rstBusy", busyTd, 0);
        checkOutput("rstFrameDone", frameDoneTd, 0);
        checkOutput("rstInReady", inReadyTd, 0);
        checkOutput("rstOutData", outDataTd, 0);
        checkOutput("rstOutValidBu", outValidBu, 0);
        expTd.delete();
        expBu.delete();
        outReady = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) begin
          @(posedge clk); #1;
          checkOutput("idleOutValid", outValidTd, 0);
          checkOutput("idleBusy", busyTd, 0);
        end
        return;
      end
      if (mode == M_BACKPRES && sent == 4 && !stallDone) begin
        stallLeft = 3;
        stallDone = 1;
      end
      if (stallLeft > 0) begin
        outReady = 1'b0;
        stallLeft--;
        checkOutput("bpStallData", outDataTd, frame[1][15:8]);
      end else if (mode == M_RANDOM) begin
        outReady = ($urandom_range(0, 3) != 0);
      end else begin
        outReady = 1'b1;
      end
      start = (mode == M_BOUNDARY) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start    = 1'b0;
    outReady = 1'b1;
    checkOutput("dumpDone", frameDoneTd, 1);
    checkOutput("dumpDoneBu", frameDoneBu, 1);
    checkOutput("doneBusy", busyTd, 0);
    checkOutput("doneOutValid", outValidTd, 0);
    checkOutput("tdQueueDrained", expTd.size(), 0);
    checkOutput("buQueueDrained", expBu.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("doneHolds", frameDoneTd, 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b1;
    {r, g, b} = 24'd0;
    #1;
    checkOutput("resetInReady", inReadyTd, 0);
    checkOutput("resetOutValid", outValidTd, 0);
    checkOutput("resetOutData", outDataTd, 0);
    checkOutput("resetBusy", busyTd, 0);
    checkOutput("resetFrameDone", frameDoneTd, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idleNoOutput", outValidTd, 0);

    applyStimulus(M_BASIC);
    applyStimulus(M_BACKPRES);
    applyStimulus(M_BOUNDARY);
    applyStimulus(M_RESETMID);
    applyStimulus(M_BASIC);
    for (int n = 0; n < 4; n++) begin
      applyStimulus(M_RANDOM);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
